// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the multi-cycle shift sequencer: FSM encodings, opcodes
// and default geometry.
package shift_sequencer_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHAMT_W = 5;

endpackage

// File: rtl/shift_sequencer_if.sv
// Start/ready handshake bundle between the pipeline and the shift sequencer.
interface shift_sequencer_if
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
);

  logic               ctrl_start;
  logic               ctrl_sra;
  logic [WIDTH-1:0]   data_operandA;
  logic [SHAMT_W-1:0] ctrl_shiftamt;
  logic               busy;
  logic               data_resultRDY;
  logic [WIDTH-1:0]   data_result;

  modport master (
    output ctrl_start, ctrl_sra, data_operandA, ctrl_shiftamt,
    input  busy, data_resultRDY, data_result
  );

  modport slave (
    input  ctrl_start, ctrl_sra, data_operandA, ctrl_shiftamt,
    output busy, data_resultRDY, data_result
  );

endinterface

// File: rtl/shift_sequencer_shift_stage.sv
// One fixed-distance stage of the logarithmic shifter: shifts by 2^STAGE,
// left with zero fill or arithmetic right with sign fill.
module shift_stage
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STAGE = 0
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             ctrl_sra,
  output logic [WIDTH-1:0] data_out
);

  localparam int DIST = 1 << STAGE;

  logic signed [WIDTH-1:0] data_s;

  always_comb begin
    data_s = data_in;
    if (ctrl_sra) data_out = data_s >>> DIST;
    else          data_out = data_in << DIST;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRA sequencer, one shifter stage per clock from 2^(SHAMT_W-1) down to 1.
// Define SHIFT_SEQ_SKIP_EN to skip stages whose shift-amount bit is clear.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic             clock,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  localparam int IDX_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

  logic [1:0]         state;
  logic               op;
  logic [SHAMT_W-1:0] shamt;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   result;

  logic [WIDTH-1:0]   stage_out [SHAMT_W];

  logic               start_found;
  logic [IDX_W-1:0]   start_idx;
  logic               step_more;
  logic [IDX_W-1:0]   step_idx;

  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .STAGE(g)) u_stage (
      .data_in  (result),
      .ctrl_sra (op == OP_SRA),
      .data_out (stage_out[g])
    );
  end

`ifdef SHIFT_SEQ_SKIP_EN
  // Highest set bit of 'bits' strictly below 'limit'; MSB of the return flags a hit.
  function automatic logic [IDX_W:0] next_set(input logic [SHAMT_W-1:0] bits, input int limit);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = 0; i < SHAMT_W; i++)
      if (i < limit && bits[i]) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  always_comb begin
    {start_found, start_idx} = next_set(bus.ctrl_shiftamt, SHAMT_W);
    {step_more, step_idx}    = next_set(shamt, int'(idx));
  end
`else
  always_comb begin
    start_found = 1'b1;
    start_idx   = IDX_W'(SHAMT_W - 1);
    step_more   = (idx != '0);
    step_idx    = idx - IDX_W'(1);
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      op     <= OP_SLL;
      shamt  <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.ctrl_start) begin
            result <= bus.data_operandA;
            op     <= bus.ctrl_sra;
            shamt  <= bus.ctrl_shiftamt;
            idx    <= start_idx;
            state  <= start_found ? SHIFT : DONE;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          if (shamt[idx]) result <= stage_out[idx];
          if (step_more) idx   <= step_idx;
          else           state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = (state == SHIFT);
  assign bus.data_resultRDY = (state == DONE);
  assign bus.data_result    = result;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle 32-bit shift unit controller that sequences a logarithmic shifter one stage per clock: stages of 16, 8, 4, 2 and 1 bits, each taken or bypassed by one bit of the shift amount.
- Supports SLL and SRA.
- Sits beside the ALU as an alternate, lower-area shift path.
- Uses the same start/ready handshake style as the multiply/divide unit, so the pipeline stall logic treats it identically.

Parameters:
- WIDTH, 32, data width; must be a power of two.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH) and also the number of stages.

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; forces the block idle
- ctrl_start  in  1  one-cycle request; sampled only when busy=0
- ctrl_sra  in  1  0 = SLL, 1 = SRA; latched at start
- data_operandA  in  WIDTH  value to shift; latched at start
- ctrl_shiftamt  in  SHAMT_W  shift amount; latched at start
- busy  out  1  high while a shift is in progress
- data_resultRDY  out  1  one-cycle pulse when data_result is valid
- data_result  out  WIDTH  shifted value; held until the next accepted start

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE, busy = 0, data_resultRDY = 0, data_result = 0.
  - Latched op, shamt and stage index are cleared to 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ctrl_start=1 at edge E0 latches data_operandA into the result register, and latches ctrl_sra and ctrl_shiftamt.
  - Stage index is set to SHAMT_W-1; next state is SHIFT.
- SHIFT:
  - Each edge applies stage k = index to the result register:
    - shamt[k]=1: shift by 2^k (SLL fills with zeros; SRA fills with bit WIDTH-1 of the current register value).
    - shamt[k]=0: register unchanged.
  - Index then decrements.
  - The edge that processes k=0 moves to DONE.
- Base latency:
  - Stages are applied at E1..E5.
  - data_resultRDY=1 during the cycle after E5.
  - Fixed at SHAMT_W+1 cycles from the start edge to the RDY pulse.
- DONE:
  - data_resultRDY=1 and busy=0 for exactly one cycle.
  - If ctrl_start=1 in DONE, a new operation is accepted (back-to-back); otherwise next state is IDLE.
- busy=1 only in SHIFT.
- ctrl_start while busy=1 is ignored: no queueing, no error.
- Input changes after the start edge have no effect.
- data_result is visible at all times but is only guaranteed correct when data_resultRDY=1 and until the next accepted start.
- Boundary cases:
  - shamt=0: result = operand, same latency as any other shift.
  - shamt=31 SRA of a negative operand: result = all ones.
  - shamt=31 SLL: only operand bit 0 survives, in bit 31.
- Reset asserted mid-SHIFT: immediate return to the reset values; no RDY pulse for the aborted operation.

Optional Feature:
- Macro: SHIFT_SEQ_SKIP_EN.
- Defined:
  - SHIFT state skips stages whose shamt bit is 0. The index jumps to the next lower set bit within the same edge as the current stage.
  - The transition to DONE happens on the edge that applies the lowest set bit.
  - shamt=0 goes IDLE -> DONE directly, so RDY appears 1 cycle after the start edge.
  - Latency = 1 + popcount(shamt) cycles from start edge to RDY when shamt≠0 (1 cycle when shamt=0).
- Undefined: fixed SHAMT_W+1 latency as above.
- Results are identical in both builds.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - opcode constants OP_SLL=1'b0, OP_SRA=1'b1
  - default WIDTH and SHAMT_W
- One natural sub-module: shift_stage.
  - Combinational; parameter STAGE selects a shift of 2^STAGE; inputs data_in and ctrl_sra; output data_out.
  - Instantiated SHAMT_W times with a generate loop.
  - The sequencer muxes among the stage outputs by stage index and shamt bit.

Test Plan:
- SLL 0x0000_0001 by 31 -> RDY one pulse, 6 cycles after start; result 0x8000_0000; busy high for exactly 5 cycles.
- SRA 0x8000_0000 by 4 -> 0xF800_0000; SRA 0x7FFF_FFFF by 31 -> 0x0000_0000; SRA 0xFFFF_FFF0 by 2 -> 0xFFFF_FFFC.
- shamt=0 on 0xDEAD_BEEF -> result 0xDEAD_BEEF.
  - Without SHIFT_SEQ_SKIP_EN: RDY after 6 cycles.
  - With SHIFT_SEQ_SKIP_EN: RDY after 1 cycle; shamt=5'b10001 -> RDY after 3 cycles.
- Start pulses while busy (operand 0x1234, shamt 3) -> ignored; original result unchanged; exactly one RDY.
- Back-to-back: start in the DONE cycle with SLL 0x0000_00FF by 8 -> previous RDY still pulses; new result 0x0000_FF00; no idle gap.
- Reset driven low mid-SHIFT (third cycle) -> outputs 0 immediately, no RDY; after release the next start completes normally.
